// File: rtl/serial_addsub.sv
// Bit-serial signed adder/subtractor: one full-adder slice plus a carry
// flop, one operand bit per clock, WIDTH-bit result with carry and overflow.
// Ports: clk, rst_n (async low), start/sub/a/b request inputs;
// busy, done pulse, result, carry_out, overflow outputs.
// Optional saturation on overflow: define SERIAL_ADDSUB_SAT_EN.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_s;
  logic             c_nxt;
  logic [WIDTH-1:0] wrapped;
  logic             ovf_now;

  // The single adder slice
  always_comb begin
    bit_s   = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    c_nxt   = (a_sh_q[0] & b_sh_q[0])
            | (c_q & (a_sh_q[0] ^ b_sh_q[0]));
    wrapped = {bit_s, r_sh_q[WIDTH-1:1]};
    // On the MSB step c_q is the carry into the MSB
    ovf_now = c_q ^ c_nxt;
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    r_sh_d   = r_sh_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          // Subtraction as a + ~b + 1, the +1 riding in on the carry
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          r_sh_d  = '0;
          c_d     = sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        r_sh_d = wrapped;
        c_d    = c_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          cout_d  = c_nxt;
          ovf_d   = ovf_now;
`ifdef SERIAL_ADDSUB_SAT_EN
          // Wrapped MSB set on overflow means the true value was positive
          if (ovf_now) begin
            result_d = wrapped[WIDTH-1]
                     ? {1'b0, {(WIDTH-1){1'b1}}}
                     : {1'b1, {(WIDTH-1){1'b0}}};
          end else begin
            result_d = wrapped;
          end
`else
          result_d = wrapped;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      r_sh_q   <= r_sh_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule
